int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that sits between the interrupt sources (timer `flag`, debounced push-buttons) and the CPU's main decoder. It latches rising-edge requests, applies a software-programmed mask, picks the highest-priority pending source, and drives `EXL`/`IV` into the decoder. It sequences one interrupt at a time through a request/acknowledge/return handshake. Mask and pending registers are written over the same 5-bit address/`we`/`dataIn` bus the timer uses.

## Interface
Parameters:
- `NSRC`, 4, number of interrupt sources; 2..8
- `ADDR_MASK`, 5'b11000, address of the mask register (write sets mask, read returns mask)
- `ADDR_PEND`, 5'b11001, address of the pending register (write-1-to-clear, read returns pending)
- `ADDR_CAUSE`, 5'b11010, address of the cause register (read-only: {valid, index})

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-low reset (0 = reset)
- `irq`  in  NSRC  level request lines; index 0 is the timer and has the highest priority
- `we`  in  1  register write strobe
- `addr`  in  5  register address
- `dataIn`  in  32  write data
- `dataOut`  out  32  combinational read data for `addr`; 0 for unmapped addresses
- `INTCTRL`  in  1  control-transfer instruction in flight; blocks interrupt entry
- `ack`  in  1  CPU has redirected the PC to the handler
- `done`  in  1  handler return (one-cycle pulse)
- `EXL`  out  1  interrupt request/in-service to the CPU
- `IV`  out  1  alternate vector select; 1 when the serviced source is index 0
- `cause`  out  clog2(NSRC)  index of the source being serviced

## Operation
- Edge detect: `irq_d` holds the previous `irq`. `pending[i]` is set when `irq[i] & ~irq_d[i]`.
- Pending clear: a write to `ADDR_PEND` clears the bits where `dataIn` is 1. `ack` clears `pending[cause]`. If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask: a write to `ADDR_MASK` loads `dataIn[NSRC-1:0]`. 1 = enabled.
- Eligible vector = `pending & mask`. The winner is the lowest set index.
- FSM states:
  - IDLE → REQ when the eligible vector is nonzero and `INTCTRL`=0. On this transition, latch `cause` = winner and `IV` = (winner==0).
  - REQ → SERV on `ack`. `pending[cause]` is cleared on the same edge.
  - SERV → IDLE on `done`.
- `EXL` = 1 in REQ and SERV, 0 in IDLE. `cause` and `IV` stay stable from REQ entry until IDLE.
- Ignored events:
  - `done` in IDLE or REQ
  - `ack` in IDLE or SERV
  - `INTCTRL` outside IDLE
- No nesting: new edges during REQ/SERV only accumulate in `pending`.
- Masking a source after REQ is entered does not withdraw the request. The committed interrupt completes.
- `ADDR_CAUSE` read value: bit 31 = (state != IDLE), low bits = `cause`, all other bits 0.

## Timing
- Reset values:
  - `pending`, `mask`, `irq_d` = 0
  - state = IDLE
  - `EXL`, `IV`, `cause` = 0
  - `dataOut` follows the registers, so it reads 0
- Latency:
  - A rising edge of `irq` sampled at edge k sets `pending` after edge k.
  - `EXL` rises after edge k+1, provided the source is unmasked, `INTCTRL`=0 and the FSM is in IDLE.
  - `ack` sampled at edge m moves the FSM to SERV after edge m.
  - `done` sampled at edge n drops `EXL` after edge n. A still-eligible source re-raises `EXL` after edge n+1 at the earliest. Minimum one IDLE cycle between interrupts.
- `INTCTRL` high holds the FSM in IDLE for every cycle it is high. Entry happens on the first edge where it is low.
- Register writes take effect on the write edge. A mask write and a pending edge in the same cycle are both evaluated at the next edge.
- Reset asserted in any state returns all registers to reset values at that edge. `EXL` is 0 the next cycle.

## Structure
- Package `int_ctrl_pkg`:
  - state enum {IDLE, REQ, SERV}
  - address constants `ADDR_MASK`, `ADDR_PEND`, `ADDR_CAUSE`
  - cause-register bit positions
- Sub-module `prio_enc` (parameter `NSRC`): inputs eligible vector; outputs `valid` and lowest-set index. Purely combinational.

## Test plan
- Reset, then `irq`=4'b0100 with mask 0 → `pending`=4'b0100, `EXL` stays 0. Write mask 4'b0100 → `EXL`=1, `cause`=2, `IV`=0 two edges later.
- Mask 4'b1111, raise `irq[3]` and `irq[0]` on the same edge → `cause`=0, `IV`=1. After `ack` and `done`, the next entry gives `cause`=3.
- `INTCTRL` high for 3 cycles while a source is eligible → `EXL`=0 throughout. `EXL`=1 one edge after `INTCTRL` falls.
- In SERV, a new `irq[1]` edge → `pending[1]` set, `EXL` stays 1, `cause` unchanged. `done` → `EXL`=0 for one cycle, then `EXL`=1 with `cause`=1.
- Write `ADDR_PEND` with 32'h1 on the same edge as an `irq[0]` rising edge → `pending[0]`=1 (set wins). Read `ADDR_CAUSE` in REQ → 32'h8000_0000 | cause.
- Drive `rst`=0 while in SERV → next cycle `EXL`=0, `pending`=0, `mask`=0, and `dataOut` at `ADDR_MASK` = 0.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
package int_ctrl_pkg;

    // Request/acknowledge/return sequencing, one interrupt at a time.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    // Default register addresses on the shared 5-bit peripheral bus.
    localparam logic [4:0] ADDR_MASK  = 5'b11000;
    localparam logic [4:0] ADDR_PEND  = 5'b11001;
    localparam logic [4:0] ADDR_CAUSE = 5'b11010;

    // Cause register layout: {busy, zeros, index}.
    localparam int CAUSE_VALID_BIT = 31;
    localparam int CAUSE_INDEX_LSB = 0;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Combinational priority encoder: lowest set bit wins.
module prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0]         i_vec,
    output logic                    o_valid,
    output logic [$clog2(NSRC)-1:0] o_index
);

    localparam int IW = $clog2(NSRC);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        // NOTE: every output gets a default before any conditional update; a path
        // that leaves a combinational output unassigned infers a latch.
        o_index = '0;
        o_valid = |i_vec;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed
// priority (index 0 highest), and a REQ/SERV handshake toward the decoder.
module int_ctrl #(
    parameter int         NSRC       = 4,
    parameter logic [4:0] ADDR_MASK  = int_ctrl_pkg::ADDR_MASK,
    parameter logic [4:0] ADDR_PEND  = int_ctrl_pkg::ADDR_PEND,
    parameter logic [4:0] ADDR_CAUSE = int_ctrl_pkg::ADDR_CAUSE,
    localparam int        CW         = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [31:0]     dataIn,
    output logic [31:0]     dataOut,
    input  logic            INTCTRL,
    input  logic            ack,
    input  logic            done,
    output logic            EXL,
    output logic            IV,
    output logic [CW-1:0]   cause
);

    import int_ctrl_pkg::state_t, int_ctrl_pkg::IDLE, int_ctrl_pkg::REQ, int_ctrl_pkg::SERV;
    import int_ctrl_pkg::CAUSE_VALID_BIT, int_ctrl_pkg::CAUSE_INDEX_LSB;

    state_t          r_state;
    state_t          w_state_next;
    logic [NSRC-1:0] r_irq_d;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_mask;
    logic [CW-1:0]   r_cause;
    logic            r_iv;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_eligible;
    logic            w_win_valid;
    logic [CW-1:0]   w_win_index;
    logic            w_enter;
    logic            w_mask_wr;
    logic            w_pend_wr;

    // Only the low NSRC bits of the write bus are meaningful here.
    logic w_unused_data;
    assign w_unused_data = &{1'b0, dataIn[31:NSRC]};

    assign w_rise     = irq & ~r_irq_d;
    assign w_eligible = r_pending & r_mask;
    assign w_mask_wr  = we && (addr == ADDR_MASK);
    assign w_pend_wr  = we && (addr == ADDR_PEND);
    assign w_enter    = (r_state == IDLE) && (w_state_next == REQ);

    prio_enc #(
        .NSRC    (NSRC)
    ) u_prio_enc (
        .i_vec   (w_eligible),
        .o_valid (w_win_valid),
        .o_index (w_win_index)
    );

    // Clear sources: software write-1-to-clear plus the acknowledged cause.
    always_comb begin
        w_clr = '0;
        if (w_pend_wr) begin
            w_clr = dataIn[NSRC-1:0];
        end
        if ((r_state == REQ) && ack) begin
            w_clr[r_cause] = 1'b1;
        end
    end

    // Edge history, pending, and mask registers; a new edge beats a clear.
    always_ff @(posedge clk) begin
        // NOTE: all state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            r_irq_d   <= '0;
            r_pending <= '0;
            r_mask    <= '0;
        end else begin
            r_irq_d   <= irq;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_mask_wr) begin
                r_mask <= dataIn[NSRC-1:0];
            end
        end
    end

    // Next-state logic for the handshake; stray ack/done/INTCTRL are ignored.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_win_valid && !INTCTRL) w_state_next = REQ;
            REQ:     if (ack)                     w_state_next = SERV;
            SERV:    if (done)                    w_state_next = IDLE;
            default:                              w_state_next = IDLE;
        endcase
    end

    // State register plus cause/IV capture, frozen until return to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: every register here is small control state and is reset
        // explicitly; nothing is left to power-up values.
        if (!rst) begin
            r_state <= IDLE;
            r_cause <= '0;
            r_iv    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_enter) begin
                r_cause <= w_win_index;
                r_iv    <= (w_win_index == '0);
            end
        end
    end

    assign EXL   = (r_state != IDLE);
    assign IV    = r_iv;
    assign cause = r_cause;

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        dataOut = '0;
        if (addr == ADDR_MASK) begin
            dataOut[NSRC-1:0] = r_mask;
        end else if (addr == ADDR_PEND) begin
            dataOut[NSRC-1:0] = r_pending;
        end else if (addr == ADDR_CAUSE) begin
            dataOut[CAUSE_VALID_BIT]                      = (r_state != IDLE);
            dataOut[CAUSE_INDEX_LSB +: CW]                = r_cause;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed register/FSM checks plus a
// scoreboard of expected {cause, IV} popped on every EXL rising edge.
module tb_int_ctrl;

    localparam int         NSRC = 4;
    localparam int         CW   = $clog2(NSRC);
    localparam logic [4:0] A_MASK  = 5'b11000;
    localparam logic [4:0] A_PEND  = 5'b11001;
    localparam logic [4:0] A_CAUSE = 5'b11010;

    typedef struct {
        logic [CW-1:0] cause;
        logic          iv;
    } sb_entry_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] irq;
    logic            we;
    logic [4:0]      addr;
    logic [31:0]     dataIn;
    logic [31:0]     dataOut;
    logic            INTCTRL;
    logic            ack;
    logic            done;
    logic            EXL;
    logic            IV;
    logic [CW-1:0]   cause;

    int        n_checks = 0;
    int        n_errors = 0;
    sb_entry_t sb_q[$];
    sb_entry_t mon_e;
    logic      prev_exl = 1'b0;
    logic [31:0] rd_val;

    always #5 clk = ~clk;

    int_ctrl #(.NSRC(NSRC)) dut (
        .clk     (clk),
        .rst     (rst),
        .irq     (irq),
        .we      (we),
        .addr    (addr),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .INTCTRL (INTCTRL),
        .ack     (ack),
        .done    (done),
        .EXL     (EXL),
        .IV      (IV),
        .cause   (cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dataOut;
    endtask

    task automatic push(input logic [CW-1:0] c, input logic v);
        sb_entry_t e;
        e.cause = c;
        e.iv    = v;
        sb_q.push_back(e);
    endtask

    task automatic wr_start(input logic [4:0] a, input logic [31:0] d);
        we     = 1'b1;
        addr   = a;
        dataIn = d;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1; tick(); done = 1'b0;
    endtask

    // Monitor: every interrupt entry must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst === 1'b1 && EXL === 1'b1 && prev_exl === 1'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_entry", 32'(cause), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_cause", 32'(cause), 32'(mon_e.cause));
                check("sb_iv", 32'(IV), 32'(mon_e.iv));
            end
        end
        prev_exl <= EXL;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; irq = '0; we = 1'b0; addr = '0; dataIn = '0;
        INTCTRL = 1'b0; ack = 1'b0; done = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Reset state
        check("rst_exl", 32'(EXL), 32'd0);
        check("rst_iv", 32'(IV), 32'd0);
        check("rst_cause", 32'(cause), 32'd0);
        rd(A_MASK, rd_val);    check("rst_mask", rd_val, 32'd0);
        rd(A_PEND, rd_val);    check("rst_pend", rd_val, 32'd0);
        rd(A_CAUSE, rd_val);   check("rst_causereg", rd_val, 32'd0);
        rd(5'b00001, rd_val);  check("unmapped_rd", rd_val, 32'd0);

        // Masked source latches pending but raises nothing; unmask enters two edges later
        irq = 4'b0100;
        tick();
        rd(A_PEND, rd_val);    check("t1_pend", rd_val, 32'h4);
        tick();
        check("t1_masked_exl", 32'(EXL), 32'd0);
        wr_start(A_MASK, 32'h4);
        push(2'd2, 1'b0);
        tick();
        we = 1'b0;
        check("t1_exl_wr_edge", 32'(EXL), 32'd0);
        tick();
        check("t1_exl", 32'(EXL), 32'd1);
        check("t1_cause", 32'(cause), 32'd2);
        check("t1_iv", 32'(IV), 32'd0);
        pulse_ack();
        rd(A_PEND, rd_val);    check("t1_pend_acked", rd_val, 32'h0);
        check("t1_serv_exl", 32'(EXL), 32'd1);
        pulse_done();
        check("t1_done_exl", 32'(EXL), 32'd0);
        irq = '0;
        tick();

        // Simultaneous sources: index 0 first, then index 3 after one IDLE cycle
        wr_start(A_MASK, 32'hF);
        tick();
        we = 1'b0;
        rd(A_MASK, rd_val);    check("t2_mask", rd_val, 32'hF);
        irq = 4'b1001;
        push(2'd0, 1'b1);
        push(2'd3, 1'b0);
        tick();
        rd(A_PEND, rd_val);    check("t2_pend", rd_val, 32'h9);
        tick();
        check("t2_cause0", 32'(cause), 32'd0);
        check("t2_iv0", 32'(IV), 32'd1);
        pulse_ack();
        pulse_done();
        check("t2_gap_exl", 32'(EXL), 32'd0);
        tick();
        check("t2_exl3", 32'(EXL), 32'd1);
        check("t2_cause3", 32'(cause), 32'd3);
        check("t2_iv3", 32'(IV), 32'd0);
        pulse_ack();
        pulse_done();
        irq = '0;
        tick();

        // INTCTRL holds off entry for as long as it is high
        INTCTRL = 1'b1;
        irq = 4'b0100;
        push(2'd2, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_blocked_exl", 32'(EXL), 32'd0);
        end
        INTCTRL = 1'b0;
        tick();
        check("t3_exl", 32'(EXL), 32'd1);
        check("t3_cause", 32'(cause), 32'd2);

        // New edge during SERV only accumulates; served after return
        pulse_ack();
        irq = 4'b0110;
        push(2'd1, 1'b0);
        tick();
        check("t4_serv_exl", 32'(EXL), 32'd1);
        check("t4_serv_cause", 32'(cause), 32'd2);
        rd(A_PEND, rd_val);    check("t4_pend", rd_val, 32'h2);
        pulse_done();
        check("t4_idle_exl", 32'(EXL), 32'd0);
        tick();
        check("t4_exl", 32'(EXL), 32'd1);
        check("t4_cause", 32'(cause), 32'd1);
        pulse_done();
        check("t4_done_in_req", 32'(EXL), 32'd1);
        rd(A_CAUSE, rd_val);   check("t4_causereg", rd_val, 32'h8000_0001);
        pulse_ack();
        pulse_done();
        irq = '0;
        tick();

        // Set wins over a same-cycle W1C; masking after REQ does not withdraw
        irq = 4'b0001;
        wr_start(A_PEND, 32'h1);
        push(2'd0, 1'b1);
        tick();
        we = 1'b0;
        rd(A_PEND, rd_val);    check("t5_set_wins", rd_val, 32'h1);
        tick();
        check("t5_exl", 32'(EXL), 32'd1);
        check("t5_iv", 32'(IV), 32'd1);
        rd(A_CAUSE, rd_val);   check("t5_causereg", rd_val, 32'h8000_0000);
        wr_start(A_MASK, 32'h0);
        tick();
        we = 1'b0;
        check("t5_masked_in_req", 32'(EXL), 32'd1);
        pulse_ack();
        rd(A_PEND, rd_val);    check("t5_pend_acked", rd_val, 32'h0);
        check("t5_serv", 32'(EXL), 32'd1);

        // Reset while in SERV
        rst = 1'b0;
        irq = '0;
        tick();
        rst = 1'b1;
        check("t6_exl", 32'(EXL), 32'd0);
        check("t6_iv", 32'(IV), 32'd0);
        check("t6_cause", 32'(cause), 32'd0);
        rd(A_PEND, rd_val);    check("t6_pend", rd_val, 32'h0);
        rd(A_MASK, rd_val);    check("t6_mask", rd_val, 32'h0);
        rd(A_CAUSE, rd_val);   check("t6_causereg", rd_val, 32'h0);

        // Write-1-to-clear on a masked pending bit
        irq = 4'b1000;
        tick();
        rd(A_PEND, rd_val);    check("t7_pend", rd_val, 32'h8);
        wr_start(A_PEND, 32'h8);
        tick();
        we = 1'b0;
        rd(A_PEND, rd_val);    check("t7_w1c", rd_val, 32'h0);
        tick();
        check("t7_exl", 32'(EXL), 32'd0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
